// File: rtl/event_counter_disp_pkg.sv
// Shared constants for the switch-event counter display path: 7-segment
// patterns (active-low {g,f,e,d,c,b,a}), accept FSM states, BCD digit width.
package event_counter_disp_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

endpackage

// File: rtl/event_counter_disp_seg7.sv
// BCD nibble to active-low 7-segment pattern; blank or out-of-range shows dark.
module seg7_decode
  import event_counter_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/event_counter_disp.sv
// Counts synchronised, hold-off-filtered event edges in 4-digit BCD and scans
// the count onto a multiplexed 7-segment display with leading-zero blanking.
module event_counter_disp
  import event_counter_disp_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYC = 16,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned SCAN_DIV    = 50000
) (
  input  logic        REG_CLK50MHZ,
  input  logic        REG_rst_n,
  input  logic        REG_event_in,
  input  logic        REG_clear,
  output logic [15:0] REG_count_bcd,
  output logic        REG_event_strobe,
  output logic        REG_overflow,
  output logic [6:0]  REG_seg,
  output logic [3:0]  REG_an
);

  localparam int unsigned HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF_CYC > 0) ? HW'(HOLDOFF_CYC - 1) : '0;
  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [2:0]    sync;
  logic          rise;
  acc_state_t    state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic          accept;
  logic [15:0]   count_inc;
  logic          carry;
  logic [DW-1:0] div_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    blank_vec;
  logic [3:0]    nibble;
  logic [6:0]    seg_next;

  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge REG_CLK50MHZ) begin
    if (!REG_rst_n) begin
      sync     <= '0;
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      sync     <= {sync[1:0], REG_event_in};
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  // With no hold-off the FSM never leaves IDLE, so every edge is accepted.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          accept = 1'b1;
          if (HOLDOFF_CYC != 0) begin
            state_next = HOLD;
            hold_next  = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_next = IDLE;
        else                hold_next  = hold_cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_inc = REG_count_bcd;
    carry     = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_inc[i*BCD_W +: BCD_W] == 4'd9) begin
          count_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          count_inc[i*BCD_W +: BCD_W] = count_inc[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Clear outranks a simultaneous event; the strobe still reports the event.
  always_ff @(posedge REG_CLK50MHZ) begin
    if (!REG_rst_n) begin
      REG_count_bcd    <= '0;
      REG_event_strobe <= 1'b0;
      REG_overflow     <= 1'b0;
    end else begin
      REG_event_strobe <= accept;
      if (REG_clear) begin
        REG_count_bcd <= '0;
        REG_overflow  <= 1'b0;
      end else if (accept) begin
        if (REG_count_bcd == 16'h9999) begin
          REG_overflow <= 1'b1;
          if (!SATURATE) REG_count_bcd <= '0;
        end else begin
          REG_count_bcd <= count_inc;
        end
      end
    end
  end

  always_comb begin
    blank_vec[0] = 1'b0;
    blank_vec[3] = (REG_count_bcd[15:12] == 4'd0);
    blank_vec[2] = blank_vec[3] && (REG_count_bcd[11:8] == 4'd0);
    blank_vec[1] = blank_vec[2] && (REG_count_bcd[7:4] == 4'd0);
    case (digit_idx)
      2'd0:    nibble = REG_count_bcd[3:0];
      2'd1:    nibble = REG_count_bcd[7:4];
      2'd2:    nibble = REG_count_bcd[11:8];
      default: nibble = REG_count_bcd[15:12];
    endcase
  end

  seg7_decode u_seg7 (
    .bcd   (nibble),
    .blank (blank_vec[digit_idx]),
    .seg   (seg_next)
  );

  always_ff @(posedge REG_CLK50MHZ) begin
    if (!REG_rst_n) begin
      div_cnt   <= '0;
      digit_idx <= '0;
      REG_an    <= '1;
      REG_seg   <= '1;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt   <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      REG_an  <= ~(4'b0001 << digit_idx);
      REG_seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_event_counter_disp.sv
// Directed bench: reset, hold-off filtering, BCD carry/wrap/saturate,
// clear collision and display scan across three parameterisations.
module tb_event_counter_disp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ev_a, ev_bc, clear;

  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic        stb_a, stb_b, stb_c;
  logic        ov_a, ov_b, ov_c;
  logic [6:0]  seg_a, seg_b, seg_c;
  logic [3:0]  an_a, an_b, an_c;

  int n_assert = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  event_counter_disp #(.HOLDOFF_CYC(16), .SATURATE(1'b0), .SCAN_DIV(4)) u_a (
    .REG_CLK50MHZ(clk), .REG_rst_n(rst_n), .REG_event_in(ev_a), .REG_clear(clear),
    .REG_count_bcd(cnt_a), .REG_event_strobe(stb_a), .REG_overflow(ov_a),
    .REG_seg(seg_a), .REG_an(an_a)
  );

  event_counter_disp #(.HOLDOFF_CYC(0), .SATURATE(1'b0), .SCAN_DIV(4)) u_b (
    .REG_CLK50MHZ(clk), .REG_rst_n(rst_n), .REG_event_in(ev_bc), .REG_clear(clear),
    .REG_count_bcd(cnt_b), .REG_event_strobe(stb_b), .REG_overflow(ov_b),
    .REG_seg(seg_b), .REG_an(an_b)
  );

  event_counter_disp #(.HOLDOFF_CYC(0), .SATURATE(1'b1), .SCAN_DIV(4)) u_c (
    .REG_CLK50MHZ(clk), .REG_rst_n(rst_n), .REG_event_in(ev_bc), .REG_clear(clear),
    .REG_count_bcd(cnt_c), .REG_event_strobe(stb_c), .REG_overflow(ov_c),
    .REG_seg(seg_c), .REG_an(an_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Two clocks high, two low: well above the minimum detectable width.
  task automatic pulse_bc();
    ev_bc = 1'b1;
    step();
    step();
    ev_bc = 1'b0;
    step();
    step();
  endtask

  initial begin : stim
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    logic [3:0] prev_an;
    logic       found;
    logic       ev_exp;

    exp_an[0] = 4'b1110; exp_seg[0] = 7'b0010010;
    exp_an[1] = 4'b1101; exp_seg[1] = 7'b1000000;
    exp_an[2] = 4'b1011; exp_seg[2] = 7'b0110000;
    exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111111;

    rst_n = 1'b0; ev_a = 1'b0; ev_bc = 1'b0; clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev_a  = ~ev_a;
      ev_bc = ~ev_bc;
      step();
    end
    chk("rst_count_a", cnt_a, 16'h0000);
    chk("rst_count_b", cnt_b, 16'h0000);
    chk("rst_an_a", {12'h0, an_a}, 16'h000f);
    chk("rst_seg_a", {9'h0, seg_a}, 16'h007f);
    chk("rst_strobe_a", {15'h0, stb_a}, 16'h0000);
    chk("rst_strobe_b", {15'h0, stb_b}, 16'h0000);
    chk("rst_ov_b", {15'h0, ov_b}, 16'h0000);

    rst_n = 1'b1; ev_a = 1'b0; ev_bc = 1'b0;
    step();
    chk("first_scan_an", {12'h0, an_a}, 16'h000e);
    chk("first_scan_seg", {9'h0, seg_a}, 16'h0040);
    step();
    step();
    chk("idle_count_a", cnt_a, 16'h0000);

    // Pulses start at edge offsets 0, 10, 20; the middle one lands in hold-off.
    for (int t = 0; t < 30; t++) begin
      ev_exp = ((t < 3) || (t >= 10 && t < 13) || (t >= 20 && t < 23));
      ev_a = ev_exp;
      step();
      chk($sformatf("holdoff_strobe_e%0d", t + 1), {15'h0, stb_a},
          {15'h0, ((t + 1) == 3 || (t + 1) == 23)});
      if (t + 1 == 3)  chk("single_count", cnt_a, 16'h0001);
      if (t + 1 == 19) chk("holdoff_ignored", cnt_a, 16'h0001);
    end
    chk("holdoff_second_count", cnt_a, 16'h0002);

    for (int i = 1; i <= 305; i++) begin
      pulse_bc();
      if (i == 9)   chk("count_0009", cnt_b, 16'h0009);
      if (i == 10)  chk("carry_0010", cnt_b, 16'h0010);
      if (i == 99)  chk("count_0099", cnt_b, 16'h0099);
      if (i == 100) chk("carry_0100", cnt_b, 16'h0100);
    end
    chk("count_0305_b", cnt_b, 16'h0305);
    chk("count_0305_c", cnt_c, 16'h0305);

    found   = 1'b0;
    prev_an = an_b;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      if (an_b == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
      prev_an = an_b;
    end
    chk("scan_sync", {15'h0, found}, 16'h0001);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("scan_an_d%0d", d), {12'h0, an_b}, {12'h0, exp_an[d]});
      chk($sformatf("scan_seg_d%0d", d), {9'h0, seg_b}, {9'h0, exp_seg[d]});
      repeat (4) step();
    end

    for (int i = 306; i <= 9999; i++) pulse_bc();
    chk("count_9999_b", cnt_b, 16'h9999);
    chk("count_9999_c", cnt_c, 16'h9999);
    chk("ov_pre_b", {15'h0, ov_b}, 16'h0000);
    chk("ov_pre_c", {15'h0, ov_c}, 16'h0000);

    pulse_bc();
    chk("wrap_count_b", cnt_b, 16'h0000);
    chk("wrap_ov_b", {15'h0, ov_b}, 16'h0001);
    chk("sat_count_c", cnt_c, 16'h9999);
    chk("sat_ov_c", {15'h0, ov_c}, 16'h0001);

    pulse_bc();
    chk("post_wrap_count_b", cnt_b, 16'h0001);
    chk("ov_sticky_b", {15'h0, ov_b}, 16'h0001);
    chk("sat_hold_c", cnt_c, 16'h9999);

    ev_bc = 1'b1;
    step();
    step();
    clear = 1'b1;
    step();
    chk("clr_strobe_b", {15'h0, stb_b}, 16'h0001);
    chk("clr_count_b", cnt_b, 16'h0000);
    chk("clr_ov_b", {15'h0, ov_b}, 16'h0000);
    chk("clr_count_c", cnt_c, 16'h0000);
    chk("clr_ov_c", {15'h0, ov_c}, 16'h0000);
    clear = 1'b0;
    ev_bc = 1'b0;
    step();
    chk("clr_strobe_end_b", {15'h0, stb_b}, 16'h0000);
    step();
    pulse_bc();
    chk("after_clr_count_b", cnt_b, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
